// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND,
        STOP
    } uart_state_t;

    localparam int DEFAULT_CLK_HZ   = 100_000_000;
    localparam int DEFAULT_BIT_RATE = 115_200;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: pulses bit_done on the last cycle of each bit period.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 868
) (
    input  logic clk_100mhz,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_done = (count == LAST) && !clear;

    // Wraps exactly on bit_done, so every bit starts from zero.
    always_ff @(posedge clk_100mhz) begin
        if (clear || bit_done) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, configurable stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int BIT_RATE     = DEFAULT_BIT_RATE,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk_100mhz,
    input  logic                    i_reset,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_txd,
    output logic                    uart_tx_busy
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int BIT_W  = $clog2(PAYLOAD_BITS + 1);
    localparam int STOP_W = $clog2(STOP_BITS + 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(PAYLOAD_BITS);
    localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS);

    uart_state_t             state;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic [BIT_W-1:0]        bit_cnt;
    logic [STOP_W-1:0]       stop_cnt;
    logic                    bit_done;
    logic                    cnt_clear;

    // Timer idles at zero so START gets a full period after acceptance.
    assign cnt_clear = i_reset || (state == IDLE);

    uart_baud_counter #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_baud (
        .clk_100mhz(clk_100mhz),
        .clear     (cnt_clear),
        .bit_done  (bit_done)
    );

    always_ff @(posedge clk_100mhz) begin
        if (i_reset) begin
            state        <= IDLE;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (uart_tx_en) begin
                        shreg        <= uart_tx_data;
                        uart_txd     <= 1'b0;
                        uart_tx_busy <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        uart_txd <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_cnt  <= BIT_W'(1);
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_BIT) begin
                            uart_txd <= 1'b1;
                            stop_cnt <= STOP_W'(1);
                            state    <= STOP;
                        end else begin
                            uart_txd <= shreg[0];
                            shreg    <= shreg >> 1;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (stop_cnt == LAST_STOP) begin
                            uart_tx_busy <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at default parameters.
module tb_uart_tx;

    localparam int CPB   = 868;
    localparam int FRAME = 10 * CPB;

    logic       clk_100mhz;
    logic       i_reset;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_txd;
    logic       uart_tx_busy;

    int n_cmp;
    int n_bad;

    uart_tx dut (
        .clk_100mhz  (clk_100mhz),
        .i_reset     (i_reset),
        .uart_tx_en  (uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .uart_txd    (uart_txd),
        .uart_tx_busy(uart_tx_busy)
    );

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    // Records one frame starting on the negedge after the accepting edge.
    // lvl[i] is the line level at the start of bit slot i (slot 0 = start bit).
    task automatic capture_frame(
        input  int         poke_at,
        input  logic [7:0] poke_data,
        input  bit         scramble,
        output logic [9:0] lvl,
        output logic [9:0] stable,
        output int         busy_n
    );
        int b;
        lvl    = '0;
        stable = '1;
        busy_n = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk_100mhz);
            b = k / CPB;
            if (k % CPB == 0) lvl[b] = uart_txd;
            else if (uart_txd !== lvl[b]) stable[b] = 1'b0;
            if (uart_tx_busy === 1'b1) busy_n++;
            if (scramble) uart_tx_data = 8'($urandom);
            if (k == poke_at) begin
                uart_tx_en   = 1'b1;
                uart_tx_data = poke_data;
            end
            if (k == poke_at + 1) uart_tx_en = 1'b0;
        end
    endtask

    task automatic start_pulse(input logic [7:0] d);
        @(negedge clk_100mhz);
        uart_tx_en   = 1'b1;
        uart_tx_data = d;
        @(posedge clk_100mhz);
        #1 uart_tx_en = 1'b0;
    endtask

    task automatic test_reset;
        i_reset    = 1'b1;
        uart_tx_en = 1'b1;
        uart_tx_data = 8'hFF;
        repeat (3) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        n_cmp++;
        if (uart_txd !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_txd: got %b want 1", uart_txd);
        end
        n_cmp++;
        if (uart_tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy_over_en: got %b want 0", uart_tx_busy);
        end
        uart_tx_en = 1'b0;
        i_reset    = 1'b0;
        repeat (4) @(negedge clk_100mhz);
        n_cmp++;
        if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: txd=%b busy=%b want 1/0",
                     uart_txd, uart_tx_busy);
        end
    endtask

    task automatic test_frame_55;
        logic [9:0] lvl, stable;
        int busy_n;
        start_pulse(8'h55);
        capture_frame(-10, 8'h00, 1'b0, lvl, stable, busy_n);
        n_cmp++;
        if (lvl !== 10'b1010101010) begin
            n_bad++;
            $display("FAIL frame55_bits: got %b want %b", lvl, 10'b1010101010);
        end
        n_cmp++;
        if (stable !== 10'h3FF) begin
            n_bad++;
            $display("FAIL frame55_bit_width: unstable slots %b want 1111111111", stable);
        end
        n_cmp++;
        if (busy_n !== FRAME) begin
            n_bad++;
            $display("FAIL frame55_busy_len: got %0d want %0d", busy_n, FRAME);
        end
        @(negedge clk_100mhz);
        n_cmp++;
        if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
            n_bad++;
            $display("FAIL frame55_end: txd=%b busy=%b want 1/0", uart_txd, uart_tx_busy);
        end
    endtask

    task automatic test_frame_a5;
        logic [9:0] lvl, stable;
        int busy_n;
        start_pulse(8'hA5);
        capture_frame(-10, 8'h00, 1'b0, lvl, stable, busy_n);
        n_cmp++;
        if (lvl !== 10'b1101001010 || stable !== 10'h3FF) begin
            n_bad++;
            $display("FAIL frameA5_bits: got %b stable %b want %b", lvl, stable, 10'b1101001010);
        end
        n_cmp++;
        if (lvl[0] !== 1'b0 || lvl[9] !== 1'b1 || lvl[8:1] !== 8'hA5) begin
            n_bad++;
            $display("FAIL frameA5_rx_decode: got %h want a5", lvl[8:1]);
        end
        @(negedge clk_100mhz);
    endtask

    task automatic test_ignore_busy;
        logic [9:0] lvl, stable;
        int busy_n;
        start_pulse(8'h3C);
        capture_frame(2000, 8'hFF, 1'b0, lvl, stable, busy_n);
        n_cmp++;
        if (lvl !== 10'b1001111000 || stable !== 10'h3FF) begin
            n_bad++;
            $display("FAIL ignore_bits: got %b stable %b want %b", lvl, stable, 10'b1001111000);
        end
        n_cmp++;
        if (busy_n !== FRAME) begin
            n_bad++;
            $display("FAIL ignore_busy_len: got %0d want %0d", busy_n, FRAME);
        end
        repeat (20) @(negedge clk_100mhz);
        n_cmp++;
        if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_no_queue: txd=%b busy=%b want 1/0", uart_txd, uart_tx_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] lvl, stable;
        int busy_n;
        @(negedge clk_100mhz);
        uart_tx_en   = 1'b1;
        uart_tx_data = 8'h00;
        @(posedge clk_100mhz);
        #1 uart_tx_data = 8'h81;
        capture_frame(-10, 8'h00, 1'b0, lvl, stable, busy_n);
        n_cmp++;
        if (lvl !== 10'b1000000000 || stable !== 10'h3FF || busy_n !== FRAME) begin
            n_bad++;
            $display("FAIL b2b_first: got %b stable %b busy %0d want %b", lvl, stable, busy_n,
                     10'b1000000000);
        end
        @(negedge clk_100mhz);
        n_cmp++;
        if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_idle_gap: txd=%b busy=%b want 1/0", uart_txd, uart_tx_busy);
        end
        @(posedge clk_100mhz);
        #1 uart_tx_en = 1'b0;
        capture_frame(-10, 8'h00, 1'b0, lvl, stable, busy_n);
        n_cmp++;
        if (lvl !== 10'b1100000010 || stable !== 10'h3FF || busy_n !== FRAME) begin
            n_bad++;
            $display("FAIL b2b_second: got %b stable %b busy %0d want %b", lvl, stable, busy_n,
                     10'b1100000010);
        end
        @(negedge clk_100mhz);
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] lvl, stable;
        int busy_n;
        start_pulse(8'h5A);
        repeat (3000) @(negedge clk_100mhz);
        n_cmp++;
        if (uart_tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midframe_busy: got %b want 1", uart_tx_busy);
        end
        i_reset = 1'b1;
        @(posedge clk_100mhz);
        #1;
        n_cmp++;
        if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_abort: txd=%b busy=%b want 1/0", uart_txd, uart_tx_busy);
        end
        @(negedge clk_100mhz);
        i_reset = 1'b0;
        repeat (5) @(negedge clk_100mhz);
        n_cmp++;
        if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: txd=%b busy=%b want 1/0", uart_txd, uart_tx_busy);
        end
        start_pulse(8'hC3);
        capture_frame(-10, 8'h00, 1'b0, lvl, stable, busy_n);
        n_cmp++;
        if (lvl !== 10'b1110000110 || stable !== 10'h3FF || busy_n !== FRAME) begin
            n_bad++;
            $display("FAIL post_reset_frame: got %b stable %b busy %0d want %b", lvl, stable,
                     busy_n, 10'b1110000110);
        end
        @(negedge clk_100mhz);
    endtask

    task automatic test_data_change;
        logic [9:0] lvl, stable;
        int busy_n;
        start_pulse(8'h96);
        capture_frame(-10, 8'h00, 1'b1, lvl, stable, busy_n);
        n_cmp++;
        if (lvl !== 10'b1100101100 || stable !== 10'h3FF) begin
            n_bad++;
            $display("FAIL data_hold: got %b stable %b want %b", lvl, stable, 10'b1100101100);
        end
        n_cmp++;
        if (lvl[8:1] !== 8'h96) begin
            n_bad++;
            $display("FAIL data_hold_decode: got %h want 96", lvl[8:1]);
        end
        @(negedge clk_100mhz);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        i_reset      = 1'b1;
        uart_tx_en   = 1'b0;
        uart_tx_data = 8'h00;
        test_reset();
        test_frame_55();
        test_frame_a5();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
